// File: rtl/z_multdiv_unit_if.sv
// Execute-stage multdiv bundle: operands and start strobes from the pipeline,
// result, status and completion pulse from the unit.
interface z_multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/z_multdiv_unit.sv
// Iterative signed multiply / restoring divide, one bit per cycle on operand
// magnitudes, with the sign applied in a final cycle before the completion pulse.
module z_multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  z_multdiv_unit_if.slave     bus
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_q, mag_d;     // |multiplicand| for MUL, |divisor| for DIV
  logic [W2-1:0]    acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  // An unsigned WIDTH-bit magnitude holds 2^(WIDTH-1) exactly.
  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + WIDTH'(1)) : bus.data_operandA;
  assign abs_b = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + WIDTH'(1)) : bus.data_operandB;

  logic [WIDTH:0] mul_sum;
  logic [W2-1:0]  mul_next;
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  logic [WIDTH:0] rem_sh, rem_diff;
  logic [W2-1:0]  div_next;
  assign rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, mag_q};
  assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic [W2-1:0]    prod_s;
  logic [WIDTH:0]   prod_top;
  logic             mul_exc;
  logic [WIDTH-1:0] quo_s;
  logic             div_exc;
  assign prod_s   = neg_q ? (~acc_q + W2'(1)) : acc_q;
  assign prod_top = prod_s[W2-1:WIDTH-1];
  assign mul_exc  = ~((&prod_top) | ~(|prod_top));
  assign quo_s    = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  // Only a positive quotient of magnitude 2^(WIDTH-1) is unrepresentable.
  assign div_exc  = ~neg_q & acc_q[WIDTH-1];

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
          state_d = bus.ctrl_MULT ? MUL : DIV;
          cnt_d   = '0;
          neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
          mag_d   = bus.ctrl_MULT ? abs_a : abs_b;
          acc_d   = {{WIDTH{1'b0}}, (bus.ctrl_MULT ? abs_b : abs_a)};
        end
      end
      MUL: begin
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = prod_s[WIDTH-1:0];
          exc_d    = mul_exc;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIV: begin
        if (mag_q == '0) begin
          state_d  = DONE;
          result_d = '0;
          exc_d    = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = quo_s;
          exc_d    = div_exc;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mag_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);
  // Low in the sign-fixup cycle and for the whole divide-by-zero shortcut.
  assign bus.busy = (cnt_q != LAST) &&
                    ((state_q == MUL) || ((state_q == DIV) && (mag_q != '0)));

endmodule

// File: tb/tb_z_multdiv_unit.sv
// Directed bench for z_multdiv_unit: a cycle-level arithmetic model checked every
// cycle, plus hand-computed results, latencies and busy counts per vector.
module tb_z_multdiv_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  z_multdiv_unit_if #(.WIDTH(WIDTH)) bus ();
  z_multdiv_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {exception, result} from plain signed arithmetic.
  function automatic logic [WIDTH:0] model_op(input logic is_mul, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    longint sa, sb, r;
    logic [63:0] rv;
    logic exc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mul) r = sa * sb;
    else if (sb == 0) return {1'b1, {WIDTH{1'b0}}};
    else r = sa / sb;
    exc = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    rv = r;
    return {exc, rv[WIDTH-1:0]};
  endfunction

  // Timing model: an accepted op completes WIDTH+1 edges later (1 edge for divide by zero).
  logic             m_active = 1'b0, m_dz = 1'b0, m_rdy = 1'b0, m_exc = 1'b0, m_pexc = 1'b0;
  logic [WIDTH-1:0] m_res = '0, m_pres = '0;
  int               m_left = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0; m_dz <= 1'b0; m_rdy <= 1'b0;
      m_res <= '0; m_exc <= 1'b0; m_left <= 0;
    end else begin
      m_rdy <= 1'b0;
      if (m_active) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_active <= 1'b0;
          m_rdy    <= 1'b1;
          m_res    <= m_pres;
          m_exc    <= m_pexc;
        end
      end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
        m_active <= 1'b1;
        m_dz     <= !bus.ctrl_MULT && (bus.data_operandB == '0);
        m_left   <= (!bus.ctrl_MULT && (bus.data_operandB == '0)) ? 1 : WIDTH + 1;
        {m_pexc, m_pres} <= model_op(bus.ctrl_MULT, bus.data_operandA, bus.data_operandB);
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy",   bus.busy, m_active && !m_dz && (m_left > 1));
    check("cyc_rdy",    bus.data_resultRDY, m_rdy);
    check("cyc_result", bus.data_result, m_res);
    check("cyc_exc",    bus.data_exception, m_exc);
  end

  typedef struct {
    logic             m;
    logic             d;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             exc;
    int               lat;
    int               busy;
  } vec_t;

  vec_t vecs [16];

  // Called at posedge+1; returns at E0+1 with operands scrambled to prove capture.
  task automatic start_op(input logic m, input logic d, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
    bus.ctrl_MULT = m;
    bus.ctrl_DIV = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk); #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic wait_done(input int first_n, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = bus.busy ? 1 : 0;
    for (int n = first_n + 1; n <= first_n + 100; n++) begin
      @(posedge clk); #1;
      if (bus.data_resultRDY) begin
        lat = n;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    if (lat == 0) check("rdy_timeout", bus.data_resultRDY, 1'b1);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int lat, bc;
    v = vecs[i];
    check($sformatf("v%0d_model_pin", i), model_op(v.m, v.a, v.b), {v.exc, v.res});
    start_op(v.m, v.d, v.a, v.b);
    wait_done(0, lat, bc);
    check($sformatf("v%0d_latency", i), lat, v.lat);
    check($sformatf("v%0d_busy_cycles", i), bc, v.busy);
    check($sformatf("v%0d_result", i), bus.data_result, v.res);
    check($sformatf("v%0d_exception", i), bus.data_exception, v.exc);
    @(posedge clk); #1;
    check($sformatf("v%0d_rdy_one_cycle", i), bus.data_resultRDY, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, bc;
    logic seen_rdy;
    vecs = '{
      '{1'b1, 1'b0, 32'd6,        32'd7,        32'd42,       1'b0, 33, 32},
      '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 33, 32},
      '{1'b1, 1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0, 33, 32},
      '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33, 32},
      '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33, 32},
      '{1'b0, 1'b1, 32'd5,        32'd0,        32'h00000000, 1'b1, 1,  0},
      '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 33, 32},
      '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33, 32},
      '{1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0, 33, 32},
      '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33, 32},
      '{1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        1'b0, 33, 32},
      '{1'b0, 1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0, 33, 32},
      '{1'b1, 1'b1, 32'd20,       32'd4,        32'd80,       1'b0, 33, 32},
      '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, 33, 32},
      '{1'b0, 1'b1, 32'd3,        32'd7,        32'd0,        1'b0, 33, 32},
      '{1'b0, 1'b1, 32'd0,        32'd0,        32'd0,        1'b1, 1,  0}
    };
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   bus.busy, 1'b0);
    check("reset_rdy",    bus.data_resultRDY, 1'b0);
    check("reset_result", bus.data_result, '0);
    check("reset_exc",    bus.data_exception, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_vec(i);

    // DIV 100/7 with an ignored MULT mid-flight, then MULT 2*3 started in the DONE cycle.
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
    end
    bus.ctrl_MULT = 1'b1;
    bus.data_operandA = 32'd9;
    bus.data_operandB = 32'd9;
    @(posedge clk); #1;
    bus.ctrl_MULT = 1'b0;
    wait_done(10, lat, bc);
    check("b2b_div_latency", lat, 33);
    check("b2b_div_result", bus.data_result, 32'd14);
    check("b2b_div_exc", bus.data_exception, 1'b0);
    start_op(1'b1, 1'b0, 32'd2, 32'd3);
    check("b2b_rdy_single", bus.data_resultRDY, 1'b0);
    wait_done(0, lat, bc);
    check("b2b_mul_latency", lat, 33);
    check("b2b_mul_busy_cycles", bc, 32);
    check("b2b_mul_result", bus.data_result, 32'd6);
    @(posedge clk); #1;

    // Reset between edges mid-multiply.
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", bus.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy",   bus.busy, 1'b0);
    check("abort_rdy",    bus.data_resultRDY, 1'b0);
    check("abort_result", bus.data_result, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen_rdy = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus.data_resultRDY) seen_rdy = 1'b1;
    end
    check("no_rdy_after_reset", seen_rdy, 1'b0);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/z_multdiv_unit.md
Name: z_multdiv_unit

Overview:
- Multi-cycle signed multiply/divide responder on the execute stage's multdiv interface.
- Accepts a one-cycle start (ctrl_MULT or ctrl_DIV) from the pipeline latch-assert logic.
- Iterates one bit per cycle, then returns a one-cycle data_resultRDY pulse so the pipeline can release its stall.
- busy tells the issuing side that the unit is occupied.

Parameters:
WIDTH, 32, operand/result width; iteration count = WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
data_operandB  input  WIDTH  multiplier / divisor (two's complement)
ctrl_MULT  input  1  start multiply; sampled on clk rising edge
ctrl_DIV  input  1  start divide; sampled on clk rising edge
data_result  output  WIDTH  product low WIDTH bits or quotient
data_exception  output  1  overflow or divide-by-zero flag, qualified by data_resultRDY
data_resultRDY  output  1  one-cycle completion pulse
busy  output  1  high while an operation is in flight

Behaviour:
- Clocking and reset: one clock (clk). reset is asynchronous and active-high.
- While reset is high, all of the following are 0: state=IDLE, counter, data_result, data_exception, data_resultRDY, busy. Internal operand/accumulator registers are cleared.
- Reset mid-operation aborts the operation. No data_resultRDY is produced for it.
- States: IDLE, MUL, DIV, DONE.
- Start acceptance:
  - A start is accepted at edge E0 when the unit is in IDLE or DONE and ctrl_MULT or ctrl_DIV is high.
  - If both are high, MULT wins.
  - A start asserted while in MUL or DIV is ignored. It is not queued.
  - Operands are captured at E0. Later operand changes have no effect.
- Busy timing: busy goes high after E0 and stays high through the last iteration cycle. It is low in IDLE and DONE.
- Iteration and latency:
  - MUL/DIV each run WIDTH iterations, on edges E1..E32.
  - The transition to DONE occurs at E33 (WIDTH+1).
  - data_resultRDY is high for exactly the one cycle following E33, then DONE→IDLE unless a new start is accepted in that same cycle.
- Output holding: data_result and data_exception update at the same edge data_resultRDY rises. They hold their values until the next completion or reset.
- Multiply:
  - Operate on magnitudes with a 2*WIDTH shift-add accumulator.
  - Apply the sign (A[msb] XOR B[msb]) after the final iteration.
  - data_result = low WIDTH bits of the signed product.
  - data_exception = 1 iff the full signed product is not equal to the sign-extension of its low WIDTH bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = A[msb] XOR B[msb]; truncate toward zero. The remainder is discarded.
  - Divisor 0 at E0: skip iteration, go to DONE at E1. data_resultRDY is high in the cycle after E1 with data_result=0, data_exception=1.
  - Dividend = most-negative value and divisor = -1: full latency, data_result=0x80000000, data_exception=1.
- Magnitude of the most-negative operand: take it as the unsigned value 2^(WIDTH-1). The internal width must cover this without loss.
- Back-to-back operation: a start accepted in the DONE cycle begins a new operation with no idle gap. data_resultRDY still pulses for only one cycle for the finished operation.

Test Plan:
- MUL 6*7 at E0 → data_resultRDY high only in the cycle after E0+33; data_result=42, data_exception=0; busy high E0+1..E0+32.
- MUL 0x00010000*0x00010000 → data_result=0x00000000, exception=1. Separately, MUL -3*5 → 0xFFFFFFF1, exception=0.
- DIV -7/2 → data_result=0xFFFFFFFD (-3), exception=0. DIV 0x80000000/0xFFFFFFFF → 0x80000000, exception=1.
- DIV 5/0 → data_resultRDY in the cycle after E0+1; data_result=0, exception=1; busy never high.
- Start DIV 100/7, pulse ctrl_MULT at E0+10 → MULT ignored; result 14 at E0+33. Then assert ctrl_MULT 2*3 in the DONE cycle → 6 exactly 33 cycles later.
- Start MUL, assert reset at E0+15 (between edges) → busy, data_result, data_resultRDY drop to 0 immediately; no data_resultRDY afterward until a new start.
